prim_secded_inv_pipe_dec: RTL and testbench
===========================================

Name: prim_secded_inv_pipe_dec

Overview:
- Parametrised, pipelined decoder for an inverted Hamming SECDED code, for the memory read path between an ECC-protected SRAM/BRAM and its bus adapter.
- Generalises the fixed 39/32 inverted decoder:
  - data width and parity matrix are parameters;
  - valid/ready pipeline of configurable depth;
  - saturating correctable/uncorrectable error counters;
  - sticky first-error syndrome/address capture for software scrubbing.

Parameters:
- DataWidth, 32, payload bits K (8..64).
- ParityWidth, 7, check bits P; codeword width N=K+P. Must satisfy 2^(P-1) >= N.
- DataCols, {7'h52,7'h16,7'h29,7'h4a,7'h62,7'h23,7'h13,7'h2c,7'h32,7'h70,7'h0e,7'h46,7'h26,7'h25,7'h0b,7'h1c,7'h07,7'h68,7'h31,7'h51,7'h0d,7'h49,7'h38,7'h45,7'h4c,7'h2a,7'h15,7'h1a,7'h34,7'h61,7'h54,7'h19}
  - K*P-bit packed H columns, data bit K-1 first.
  - Each column odd weight >=3, all distinct.
  - Parity bit j has column one-hot(j).
- InvMask, 39'h2a00000000, N-bit XOR mask applied to the codeword before syndrome computation (inverted-code convention).
- PipeStages, 2, register stages between input and output, 1..3.
- AddrWidth, 16, width of sideband address tag.
- CntWidth, 16, width of each error counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  codeword valid.
- in_ready_o  out  1  decoder can accept.
- in_data_i  in  N  codeword, data in [K-1:0], parity in [N-1:K].
- in_addr_i  in  AddrWidth  sideband tag, passed through.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts.
- out_data_o  out  K  corrected data.
- out_addr_o  out  AddrWidth  tag aligned with out_data_o.
- out_err_o  out  2  [0] single-bit corrected, [1] uncorrectable.
- out_syndrome_o  out  P  syndrome of this word.
- cnt_clr_i  in  1  synchronous clear of counters and capture.
- ce_cnt_o  out  CntWidth  correctable error count.
- ue_cnt_o  out  CntWidth  uncorrectable error count.
- cap_valid_o  out  1  a first error has been captured.
- cap_syndrome_o  out  P  syndrome of the first error since clear.
- cap_addr_o  out  AddrWidth  address of the first error since clear.

Behaviour:
- Decode (combinational, stage 1 input):
  - Codeword c = in_data_i ^ InvMask.
  - syndrome[j] = XOR of c bits whose H column has bit j set.
  - Data bit i flips iff syndrome == DataCols[i].
  - err[0] = ^syndrome; err[1] = ~err[0] & |syndrome.
  - Syndrome matching a parity column or no column: data unchanged.
  - Zero syndrome: no error.
- Pipeline:
  - PipeStages registers; each stage holds valid, data, addr, err, syndrome.
  - Stage k advances when its valid is 0 or the downstream stage advances.
  - in_ready_o = stage-1 advance condition; out_valid_o = last-stage valid.
  - Latency is exactly PipeStages cycles with out_ready_i held high; full throughput of 1 word/cycle.
  - With out_ready_i low, the pipe fills and in_ready_o drops once all stages are valid.
  - Output fields are held stable while out_valid_o & ~out_ready_i.
  - No combinational path from in_valid_i to out_valid_o. in_ready_o may depend combinationally on out_ready_i.
- Counters update on output handshake (out_valid_o & out_ready_i):
  - ce_cnt_o increments if err[0]; ue_cnt_o increments if err[1].
  - Both saturate at all-ones, no wrap.
- Capture:
  - On the first handshake with nonzero err while cap_valid_o=0, latch syndrome and addr and set cap_valid_o.
  - Later errors do not overwrite the capture.
- cnt_clr_i:
  - Zeroes both counters and cap_valid_o/cap_*.
  - Has priority over a same-cycle increment or capture; the event in that cycle is dropped.
  - Does not affect pipeline contents.
- Reset (async assert, sync deassert upstream):
  - All stage valids 0; out_* data/addr/err/syndrome 0.
  - Counters 0; cap_valid_o 0; cap_* 0.
  - in_ready_o = 1 after reset.
  - Reset mid-burst discards all in-flight words.

Test Plan:
- Clean word: in_data_i = encode(32'hDEADBEEF) ^ InvMask applied as stored, PipeStages=2 -> out_data_o=32'hDEADBEEF, out_err_o=0, syndrome 0, at cycle +2; counters stay 0.
- Single flip of data bit 0 -> syndrome 7'h19, data corrected, err=2'b01, ce_cnt_o=1, cap_valid_o=1, cap_addr_o=tag. Repeat on each of all 39 bit positions; parity-bit flips give err=01 with data unchanged.
- Double flip of bits 3 and 17 -> err=2'b10, ue_cnt_o increments, out_data_o is raw data, cap not overwritten if already set.
- Backpressure: stream 8 words, hold out_ready_i low 5 cycles. Expect:
  - in_ready_o low after 2 accepts;
  - no loss or duplication;
  - order preserved;
  - outputs stable while stalled.
- Saturation/clear: with CntWidth=4, inject 20 CEs -> ce_cnt_o=15. Assert cnt_clr_i in the same cycle as an error handshake -> counters 0 and cap_valid_o 0.
- Assert rst_ni low with 2 words in flight -> out_valid_o=0 immediately, counters 0, in_ready_o=1 after release.

Source files
------------

// File: rtl/prim_secded_inv_pipe_dec.sv
// rtl/prim_secded_inv_pipe_dec.sv - pipelined inverted Hamming SECDED decoder with error counters and capture
module prim_secded_inv_pipe_dec #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned ParityWidth = 7,
    parameter logic [DataWidth*ParityWidth-1:0] DataCols = {
        7'h52, 7'h16, 7'h29, 7'h4a, 7'h62, 7'h23, 7'h13, 7'h2c,
        7'h32, 7'h70, 7'h0e, 7'h46, 7'h26, 7'h25, 7'h0b, 7'h1c,
        7'h07, 7'h68, 7'h31, 7'h51, 7'h0d, 7'h49, 7'h38, 7'h45,
        7'h4c, 7'h2a, 7'h15, 7'h1a, 7'h34, 7'h61, 7'h54, 7'h19},
    parameter logic [DataWidth+ParityWidth-1:0] InvMask = 39'h2a00000000,
    parameter int unsigned PipeStages  = 2,
    parameter int unsigned AddrWidth   = 16,
    parameter int unsigned CntWidth    = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [DataWidth+ParityWidth-1:0]   in_data_i,
    input  logic [AddrWidth-1:0]               in_addr_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [DataWidth-1:0]               out_data_o,
    output logic [AddrWidth-1:0]               out_addr_o,
    output logic [1:0]                         out_err_o,
    output logic [ParityWidth-1:0]             out_syndrome_o,
    input  logic                               cnt_clr_i,
    output logic [CntWidth-1:0]                ce_cnt_o,
    output logic [CntWidth-1:0]                ue_cnt_o,
    output logic                               cap_valid_o,
    output logic [ParityWidth-1:0]             cap_syndrome_o,
    output logic [AddrWidth-1:0]               cap_addr_o
);

    localparam int unsigned K = DataWidth;
    localparam int unsigned P = ParityWidth;
    localparam int unsigned N = DataWidth + ParityWidth;
    localparam int unsigned S = PipeStages;

    if (S < 1 || S > 3) begin : g_bad_stages
        $error("PipeStages must be in 1..3");
    end
    if ((1 << (P - 1)) < N) begin : g_bad_parity
        $error("ParityWidth too small for codeword width");
    end

    // Remove the storage inversion first so the H matrix applies to a plain Hamming word.
    logic [N-1:0] cw;
    logic [P-1:0] dec_syn;
    logic [K-1:0] dec_data;
    logic [1:0]   dec_err;

    assign cw = in_data_i ^ InvMask;

    always_comb begin
        dec_syn = cw[N-1:K];
        for (int i = 0; i < int'(K); i++) begin
            if (cw[i]) dec_syn = dec_syn ^ DataCols[i*P +: P];
        end
        for (int i = 0; i < int'(K); i++) begin
            dec_data[i] = cw[i] ^ (dec_syn == DataCols[i*P +: P]);
        end
        dec_err[0] = ^dec_syn;
        dec_err[1] = ~dec_err[0] & (|dec_syn);
    end

    logic [S-1:0] vld_q;
    logic [S-1:0] vld_d;
    logic [S-1:0] adv;
    logic [K-1:0]         data_q [S];
    logic [K-1:0]         data_d [S];
    logic [AddrWidth-1:0] addr_q [S];
    logic [AddrWidth-1:0] addr_d [S];
    logic [1:0]           err_q  [S];
    logic [1:0]           err_d  [S];
    logic [P-1:0]         syn_q  [S];
    logic [P-1:0]         syn_d  [S];

    for (genvar k = 0; k < int'(S); k++) begin : g_stage_in
        if (k == 0) begin : g_first
            assign vld_d[k]  = in_valid_i;
            assign data_d[k] = dec_data;
            assign addr_d[k] = in_addr_i;
            assign err_d[k]  = dec_err;
            assign syn_d[k]  = dec_syn;
        end else begin : g_next
            assign vld_d[k]  = vld_q[k-1];
            assign data_d[k] = data_q[k-1];
            assign addr_d[k] = addr_q[k-1];
            assign err_d[k]  = err_q[k-1];
            assign syn_d[k]  = syn_q[k-1];
        end
    end

    // A stage moves when any stage between it and the output has a hole, or the consumer takes a word.
    always_comb begin
        adv = '0;
        for (int k = 0; k < int'(S); k++) begin
            logic a;
            a = out_ready_i;
            for (int m = k; m < int'(S); m++) begin
                a = a | ~vld_q[m];
            end
            adv[k] = a;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int k = 0; k < int'(S); k++) begin
                data_q[k] <= '0;
                addr_q[k] <= '0;
                err_q[k]  <= '0;
                syn_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < int'(S); k++) begin
                if (adv[k]) begin
                    vld_q[k]  <= vld_d[k];
                    data_q[k] <= data_d[k];
                    addr_q[k] <= addr_d[k];
                    err_q[k]  <= err_d[k];
                    syn_q[k]  <= syn_d[k];
                end
            end
        end
    end

    assign in_ready_o     = adv[0];
    assign out_valid_o    = vld_q[S-1];
    assign out_data_o     = data_q[S-1];
    assign out_addr_o     = addr_q[S-1];
    assign out_err_o      = err_q[S-1];
    assign out_syndrome_o = syn_q[S-1];

    logic                 hs;
    logic [CntWidth-1:0]  ce_q, ce_d, ue_q, ue_d;
    logic                 cap_vld_q, cap_vld_d;
    logic [P-1:0]         cap_syn_q, cap_syn_d;
    logic [AddrWidth-1:0] cap_addr_q, cap_addr_d;

    assign hs = out_valid_o & out_ready_i;

    // Clear wins over a same-cycle event; the event is intentionally lost.
    always_comb begin
        ce_d       = ce_q;
        ue_d       = ue_q;
        cap_vld_d  = cap_vld_q;
        cap_syn_d  = cap_syn_q;
        cap_addr_d = cap_addr_q;
        if (cnt_clr_i) begin
            ce_d       = '0;
            ue_d       = '0;
            cap_vld_d  = 1'b0;
            cap_syn_d  = '0;
            cap_addr_d = '0;
        end else if (hs) begin
            if (out_err_o[0] && (ce_q != '1)) ce_d = ce_q + 1'b1;
            if (out_err_o[1] && (ue_q != '1)) ue_d = ue_q + 1'b1;
            if ((|out_err_o) && !cap_vld_q) begin
                cap_vld_d  = 1'b1;
                cap_syn_d  = out_syndrome_o;
                cap_addr_d = out_addr_o;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ce_q       <= '0;
            ue_q       <= '0;
            cap_vld_q  <= 1'b0;
            cap_syn_q  <= '0;
            cap_addr_q <= '0;
        end else begin
            ce_q       <= ce_d;
            ue_q       <= ue_d;
            cap_vld_q  <= cap_vld_d;
            cap_syn_q  <= cap_syn_d;
            cap_addr_q <= cap_addr_d;
        end
    end

    assign ce_cnt_o       = ce_q;
    assign ue_cnt_o       = ue_q;
    assign cap_valid_o    = cap_vld_q;
    assign cap_syndrome_o = cap_syn_q;
    assign cap_addr_o     = cap_addr_q;

endmodule

// File: tb/tb_prim_secded_inv_pipe_dec.sv
// tb/tb_prim_secded_inv_pipe_dec.sv - scoreboard bench for prim_secded_inv_pipe_dec
module tb_prim_secded_inv_pipe_dec;

    localparam int K  = 32;
    localparam int P  = 7;
    localparam int N  = 39;
    localparam int AW = 16;
    localparam int CW = 4;
    localparam logic [K*P-1:0] DCOLS = {
        7'h52, 7'h16, 7'h29, 7'h4a, 7'h62, 7'h23, 7'h13, 7'h2c,
        7'h32, 7'h70, 7'h0e, 7'h46, 7'h26, 7'h25, 7'h0b, 7'h1c,
        7'h07, 7'h68, 7'h31, 7'h51, 7'h0d, 7'h49, 7'h38, 7'h45,
        7'h4c, 7'h2a, 7'h15, 7'h1a, 7'h34, 7'h61, 7'h54, 7'h19};
    localparam logic [N-1:0] INV = 39'h2a00000000;

    typedef struct {
        logic [K-1:0]  d;
        logic [AW-1:0] a;
        logic [1:0]    e;
        logic [P-1:0]  s;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [AW-1:0] in_addr;
    logic          out_valid;
    logic          out_ready;
    logic [K-1:0]  out_data;
    logic [AW-1:0] out_addr;
    logic [1:0]    out_err;
    logic [P-1:0]  out_syn;
    logic          cnt_clr;
    logic [CW-1:0] ce_cnt;
    logic [CW-1:0] ue_cnt;
    logic          cap_valid;
    logic [P-1:0]  cap_syn;
    logic [AW-1:0] cap_addr;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prim_secded_inv_pipe_dec #(
        .CntWidth (CW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .in_addr_i      (in_addr),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .out_addr_o     (out_addr),
        .out_err_o      (out_err),
        .out_syndrome_o (out_syn),
        .cnt_clr_i      (cnt_clr),
        .ce_cnt_o       (ce_cnt),
        .ue_cnt_o       (ue_cnt),
        .cap_valid_o    (cap_valid),
        .cap_syndrome_o (cap_syn),
        .cap_addr_o     (cap_addr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [P-1:0] col(input int i);
        logic [K*P-1:0] dc;
        dc = DCOLS;
        return dc[i*P +: P];
    endfunction

    function automatic logic [N-1:0] encode(input logic [K-1:0] d);
        logic [P-1:0] p;
        p = '0;
        for (int i = 0; i < K; i++) if (d[i]) p = p ^ col(i);
        return {p, d} ^ INV;
    endfunction

    function automatic exp_t mk(input logic [K-1:0] d, input logic [AW-1:0] a,
                                input logic [1:0] e, input logic [P-1:0] s);
        exp_t x;
        x.d = d; x.a = a; x.e = e; x.s = s;
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] w, input logic [AW-1:0] a, input exp_t e);
        int n;
        in_valid = 1'b1;
        in_data  = w;
        in_addr  = a;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) break;
        end
        if (n > 100) begin
            chk("send_timeout_in_ready", in_ready, 1);
            in_valid = 1'b0;
        end else begin
            sb.push_back(e);
            step();
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            if (sb.size() == 0) break;
            step();
        end
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            chk("sb_nonempty_at_output", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_addr", out_addr, e.a);
                chk("out_err", out_err, e.e);
                chk("out_syndrome", out_syn, e.s);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [K-1:0] d;
        logic [N-1:0] w;
        logic [P-1:0] s;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_addr   = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_ce", ce_cnt, 0);
        chk("rst_ue", ue_cnt, 0);
        chk("rst_cap_valid", cap_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // clean word, latency check
        send(encode(32'hDEADBEEF), 16'h1000, mk(32'hDEADBEEF, 16'h1000, 2'b00, 7'h00));
        chk("lat_cycle1_valid", out_valid, 0);
        step();
        chk("lat_cycle2_valid", out_valid, 1);
        drain();
        chk("clean_ce", ce_cnt, 0);
        chk("clean_ue", ue_cnt, 0);
        chk("clean_cap_valid", cap_valid, 0);

        // single flip on data bit 0
        d = 32'h12345678;
        send(encode(d) ^ 39'd1, 16'h0100, mk(d, 16'h0100, 2'b01, 7'h19));
        drain();
        chk("sbe0_ce", ce_cnt, 1);
        chk("sbe0_cap_valid", cap_valid, 1);
        chk("sbe0_cap_addr", cap_addr, 16'h0100);
        chk("sbe0_cap_syn", cap_syn, 7'h19);

        // every bit position, streamed back to back
        for (int b = 0; b < N; b++) begin
            d = $urandom;
            w = encode(d) ^ (39'd1 << b);
            s = '0;
            if (b < K) s = col(b);
            else       s[b-K] = 1'b1;
            send(w, AW'(b), mk(d, AW'(b), 2'b01, s));
        end
        drain();
        chk("sweep_ce_saturated", ce_cnt, 15);
        chk("sweep_ue", ue_cnt, 0);
        chk("sweep_cap_addr_kept", cap_addr, 16'h0100);

        // double flip of bits 3 and 17
        d = 32'hCAFEF00D;
        w = encode(d) ^ (39'd1 << 3) ^ (39'd1 << 17);
        send(w, 16'h0222, mk(d ^ 32'h0002_0008, 16'h0222, 2'b10, col(3) ^ col(17)));
        drain();
        chk("dbe_ue", ue_cnt, 1);
        chk("dbe_cap_addr_kept", cap_addr, 16'h0100);
        chk("dbe_cap_syn_kept", cap_syn, 7'h19);

        // backpressure
        out_ready = 1'b0;
        send(encode(32'hA500_0000), 16'h0200, mk(32'hA500_0000, 16'h0200, 2'b00, 7'h00));
        send(encode(32'hA500_0001), 16'h0201, mk(32'hA500_0001, 16'h0201, 2'b00, 7'h00));
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_stall_in_ready", in_ready, 0);
            chk("bp_stall_valid", out_valid, 1);
            chk("bp_stall_data", out_data, 32'hA500_0000);
            chk("bp_stall_addr", out_addr, 16'h0200);
            step();
        end
        out_ready = 1'b1;
        for (int i = 2; i < 8; i++) begin
            d = 32'hA500_0000 + i;
            send(encode(d), AW'(16'h0200 + i), mk(d, AW'(16'h0200 + i), 2'b00, 7'h00));
        end
        drain();

        // clear, then saturate with 20 CEs
        @(negedge clk) cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_ce", ce_cnt, 0);
        chk("clr_ue", ue_cnt, 0);
        chk("clr_cap_valid", cap_valid, 0);
        chk("clr_cap_addr", cap_addr, 0);
        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            send(encode(d) ^ (39'd1 << (i % K)), AW'(16'h0300 + i),
                 mk(d, AW'(16'h0300 + i), 2'b01, col(i % K)));
        end
        drain();
        chk("sat_ce", ce_cnt, 15);
        chk("sat_cap_addr", cap_addr, 16'h0300);

        // clear in the same cycle as an error handshake
        d = 32'h0BAD_F00D;
        w = encode(d) ^ (39'd1 << 3) ^ (39'd1 << 17);
        send(w, 16'h0400, mk(d ^ 32'h0002_0008, 16'h0400, 2'b10, col(3) ^ col(17)));
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("clrhs_out_valid", out_valid, 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clrhs_ce", ce_cnt, 0);
        chk("clrhs_ue", ue_cnt, 0);
        chk("clrhs_cap_valid", cap_valid, 0);
        drain();

        // reset with two words in flight
        d = 32'h5555_AAAA;
        send(encode(d) ^ (39'd1 << 5), 16'h0500, mk(d, 16'h0500, 2'b01, col(5)));
        drain();
        chk("pre_rst_ce", ce_cnt, 1);
        send(encode(32'h1), 16'h0601, mk(32'h1, 16'h0601, 2'b00, 7'h00));
        send(encode(32'h2), 16'h0602, mk(32'h2, 16'h0602, 2'b00, 7'h00));
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_ce", ce_cnt, 0);
        chk("midrst_cap_valid", cap_valid, 0);
        chk("midrst_out_data", out_data, 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("postrst_in_ready", in_ready, 1);
        chk("postrst_out_valid", out_valid, 0);

        send(encode(32'h600D_CAFE), 16'h0700, mk(32'h600D_CAFE, 16'h0700, 2'b00, 7'h00));
        drain();
        chk("final_ce", ce_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
